instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder: owns the PC, issues word reads to a
//  1-cycle-latency instruction memory and buffers returned words in a 2-entry queue.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_fifo_chk.sv | 17 +
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with flush and wrapping pointers.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);
    fetch_entry_t   mem_r [DEPTH];
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [CW-1:0]  count_r;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Storage, pointers and occupancy; flush drops everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head and occupancy views.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
    end

    fetch_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );
endmodule

// File: rtl/fetch_fifo_chk.sv
// Occupancy invariants of the fetch buffer.
module fetch_fifo_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push && !pop && (count == CW'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(pop && (count == '0)));
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues 1-cycle memory reads, buffers words for the decoder,
// and flushes on redirect.
module instr_fetch #(
    parameter int              N        = fetch_pkg::ILEN,
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [N-1:0]    imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [N-1:0]    if_out,
    output logic [XLEN-1:0] if_pc
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inflight_pc_r;
    logic            inflight_r;
    logic            run_r;
    logic [CW-1:0]   count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;
    logic            pop_s;
    logic            push_s;
    logic            issue_s;

    // Handshake, issue decision and gated decoder-facing outputs.
    always_comb begin
        if_valid = (count_s != '0) && !redirect_valid;
        pop_s    = if_valid && if_ready;
        push_s   = inflight_r && !redirect_valid;
        // Only issue when the reply is guaranteed a slot: buffered + in flight - leaving.
        issue_s  = run_r && !redirect_valid &&
                   ((int'(count_s) + int'(inflight_r) - int'(pop_s)) < DEPTH);
        imem_req  = issue_s;
        imem_addr = pc_r;
        push_entry_s.pc    = inflight_pc_r;
        push_entry_s.instr = imem_rdata;
        if (if_valid) begin
            if_out = head_s.instr;
            if_pc  = head_s.pc;
        end else begin
            if_out = '0;
            if_pc  = '0;
        end
    end

    // PC and in-flight tracking; run_r holds requests off until the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            inflight_pc_r <= RESET_PC;
            inflight_r    <= 1'b0;
            run_r         <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (redirect_valid) begin
                pc_r       <= align_pc(redirect_pc);
                inflight_r <= 1'b0;
            end else if (issue_s) begin
                pc_r          <= pc_r + PC_STEP;
                inflight_r    <= 1'b1;
                inflight_pc_r <= pc_r;
            end else begin
                inflight_r <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_s),
        .count     (count_s)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of expected PCs plus directed timing checks.
module tb_instr_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req, redirect_valid, if_valid, if_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_out, if_pc;
    logic        rst5_n, req5, valid5;
    logic [31:0] addr5, rdata5, out5, pc5;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    int          n;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_out(if_out), .if_pc(if_pc)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut5 (
        .clk(clk), .rst_n(rst5_n), .imem_req(req5), .imem_addr(addr5),
        .imem_rdata(rdata5), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(valid5), .if_ready(1'b1), .if_out(out5), .if_pc(pc5)
    );

    initial begin
        imem_rdata = 32'h0;
        rdata5     = 32'h0;
    end
    always @(posedge clk) if (imem_req) imem_rdata <= 32'hA000_0000 | imem_addr;
    always @(posedge clk) if (req5) rdata5 <= 32'hA000_0000 | addr5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i) * 32'd4);
    endtask

    // Scoreboard: every accepted instruction must be the next expected PC.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_pc", if_pc, sb_e);
                check("sb_out", if_out, 32'hA000_0000 | sb_e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rst5_n = 1'b0; if_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        refill(32'h0);
        repeat (3) step();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_out", if_out, 32'h0);
        check("rst_pc", if_pc, 32'h0);

        // Startup latency and back-to-back delivery
        step(); rst_n = 1'b1;
        n = 0;
        while (!imem_req && n < 10) begin @(negedge clk); n++; end
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 10);
        check("first_lat", 32'(n), 32'd2);
        check("first_pc", if_pc, 32'h0);
        check("first_out", if_out, 32'hA000_0000);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("seq_valid", 32'(if_valid), 32'd1);
            check("seq_pc", if_pc, 32'(k) * 32'd4);
        end

        // Backpressure: buffer fills to two, requests stop, head holds
        step(); if_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(if_valid), 32'd1);
            check("hold_pc", if_pc, exp_q[0]);
        end
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_count", 32'(dut.u_fifo.count), 32'd2);
        step(); if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("resume_valid", 32'(if_valid), 32'd1);
        end

        // Redirect with buffered data and a read in flight; low bits of target dropped
        step(); if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        refill(32'h100);
        @(negedge clk);
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_req", 32'(imem_req), 32'd0);
        step(); redirect_valid = 1'b0; if_ready = 1'b1;
        @(negedge clk);
        check("redir_req1", 32'(imem_req), 32'd1);
        check("redir_addr1", imem_addr, 32'h100);
        n = 1;
        do begin @(negedge clk); n++; end while (!if_valid && n < 12);
        check("redir_lat", 32'(n), 32'd3);
        check("redir_pc", if_pc, 32'h100);
        repeat (3) @(negedge clk);

        // Redirect beats a same-cycle handshake; back-to-back redirects, last wins
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200; refill(32'h200);
        @(negedge clk);
        check("rd_hs_valid", 32'(if_valid), 32'd0);
        step(); redirect_pc = 32'h302; refill(32'h300);
        step(); redirect_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 10);
        check("b2b_pc", if_pc, 32'h300);
        check("b2b_out", if_out, 32'hA000_0300);
        repeat (4) @(negedge clk);

        // Reset while a read is in flight
        step(); if_ready = 1'b0;
        check("pre_rst_inflight", 32'(dut.inflight_r), 32'd1);
        #2; rst_n = 1'b0; #1;
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_out", if_out, 32'h0);
        check("mid_rst_pc", if_pc, 32'h0);
        refill(32'h0);
        step(); step(); if_ready = 1'b1; rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 10);
        check("post_rst_pc", if_pc, 32'h0);
        check("post_rst_out", if_out, 32'hA000_0000);
        repeat (3) @(negedge clk);

        // PC wrap from the top of the address space
        step(); rst5_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!valid5 && n < 10);
        check("wrap_pc0", pc5, 32'hFFFF_FFFC);
        check("wrap_out0", out5, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_valid1", 32'(valid5), 32'd1);
        check("wrap_pc1", pc5, 32'h0);
        check("wrap_out1", out5, 32'hA000_0000);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
